// File: rtl/input_debounce.sv
// input_debounce: 2-flop synchronize and debounce 4 buttons + 4 switches, with press pulses.
// Optional press counter compiled in with INPUT_DEBOUNCE_PRESS_CNT_EN.
module input_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [3:0] button_raw,
    input  logic [3:0] dipsw_raw,
    output logic [3:0] button_db,
    output logic [3:0] dipsw_db,
    output logic [3:0] button_press,
    output logic [7:0] press_count
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Buttons are active-low, so their idle/reset level is 1; switches idle at 0.
    localparam logic [7:0] IDLE = 8'h0F;
    logic [7:0]       sync1, sync2, stable, stable_nxt, differ, accept;
    logic [CNT_W-1:0] cnt [8];
    logic [CNT_W-1:0] cnt_nxt [8];
    logic [3:0]       press_nxt;
    always_comb begin
        differ     = sync2 ^ stable;
        accept     = 8'h00;
        for (int i = 0; i < 8; i++) begin
            accept[i]  = differ[i] && (cnt[i] == LAST);
            cnt_nxt[i] = (differ[i] && !accept[i]) ? cnt[i] + 1'b1 : '0;
        end
        stable_nxt = stable ^ accept;
        press_nxt  = stable[3:0] & ~stable_nxt[3:0];
    end
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1        <= IDLE;
            sync2        <= IDLE;
            stable       <= IDLE;
            button_press <= 4'h0;
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
        end else begin
            sync1        <= {dipsw_raw, button_raw};
            sync2        <= sync1;
            stable       <= stable_nxt;
            button_press <= press_nxt;
            for (int i = 0; i < 8; i++) cnt[i] <= cnt_nxt[i];
        end
    end
    assign button_db = stable[3:0];
    assign dipsw_db  = stable[7:4];
`ifdef INPUT_DEBOUNCE_PRESS_CNT_EN
    logic [7:0] count_q;
    logic [2:0] pop;
    always_comb begin
        pop = 3'd0;
        for (int i = 0; i < 4; i++) pop = pop + 3'(button_press[i]);
    end
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) count_q <= 8'h00;
        else                count_q <= count_q + 8'(pop);
    end
    assign press_count = count_q;
`else
    assign press_count = 8'h00;
`endif
endmodule

// File: tb/tb_input_debounce.sv
// tb_input_debounce: directed checks of input_debounce with DEBOUNCE_CYCLES=4, CNT_W=3.
module tb_input_debounce;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] button_raw, dipsw_raw;
    logic [3:0] button_db, dipsw_db, button_press;
    logic [7:0] press_count;
    logic [7:0] exp_cnt;
    int         n_tests = 0;
    int         n_fail  = 0;

    input_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk_clk(clk),
        .reset_reset_n(rst_n),
        .button_raw(button_raw),
        .dipsw_raw(dipsw_raw),
        .button_db(button_db),
        .dipsw_db(dipsw_db),
        .button_press(button_press),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bump(input logic [3:0] m);
`ifdef INPUT_DEBOUNCE_PRESS_CNT_EN
        exp_cnt = exp_cnt + 8'($countones(m));
`endif
    endtask

    // Press buttons in m, hold until accepted, then release and let it settle.
    task automatic press_release(input logic [3:0] m);
        button_raw = ~m;
        tick(5);
        check("round_pre_db", {4'h0, button_db}, 8'h0F);
        tick(1);
        check("round_db", {4'h0, button_db}, {4'h0, ~m});
        check("round_press", {4'h0, button_press}, {4'h0, m});
        tick(1);
        check("round_press_end", {4'h0, button_press}, 8'h00);
        bump(m);
        check("round_count", press_count, exp_cnt);
        button_raw = 4'hF;
        tick(6);
        check("round_release", {button_press, button_db}, 8'h0F);
        tick(1);
    endtask

    initial begin
        exp_cnt    = 8'h00;
        rst_n      = 1'b0;
        button_raw = 4'hF;
        dipsw_raw  = 4'h0;
        tick(3);
        check("rst_button_db", {4'h0, button_db}, 8'h0F);
        check("rst_dipsw_db", {4'h0, dipsw_db}, 8'h00);
        check("rst_press", {4'h0, button_press}, 8'h00);
        check("rst_count", press_count, 8'h00);
        rst_n = 1'b1;
        tick(2);

        // clean press on button 0: accepted on the 6th edge
        button_raw = 4'hE;
        tick(5);
        check("clean_pre_db", {4'h0, button_db}, 8'h0F);
        check("clean_pre_press", {4'h0, button_press}, 8'h00);
        tick(1);
        check("clean_db", {4'h0, button_db}, 8'h0E);
        check("clean_press", {4'h0, button_press}, 8'h01);
        tick(1);
        check("clean_press_end", {4'h0, button_press}, 8'h00);
        bump(4'h1);
        check("clean_count", press_count, exp_cnt);
        button_raw = 4'hF;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            check("release_no_pulse", {4'h0, button_press}, 8'h00);
        end
        check("release_db", {4'h0, button_db}, 8'h0F);

        // bounce on button 2: low 3 / high 1 / low 2 / high
        for (int i = 0; i < 14; i++) begin
            button_raw = (i < 3 || i == 4 || i == 5) ? 4'hB : 4'hF;
            tick(1);
            check("bounce", {button_press, button_db}, 8'h0F);
        end

        // walk press_count up to FE, then four simultaneous presses
        for (int r = 0; r < 63; r++) press_release(4'hF);
        press_release(4'h1);
`ifdef INPUT_DEBOUNCE_PRESS_CNT_EN
        check("count_fe", press_count, 8'hFE);
`else
        check("count_off", press_count, 8'h00);
`endif
        press_release(4'hF);
`ifdef INPUT_DEBOUNCE_PRESS_CNT_EN
        check("count_wrap", press_count, 8'h02);
`else
        check("count_wrap_off", press_count, 8'h00);
`endif

        // switch path
        dipsw_raw = 4'hA;
        tick(5);
        check("dip_pre", {4'h0, dipsw_db}, 8'h00);
        tick(1);
        check("dip_db", {4'h0, dipsw_db}, 8'h0A);
        check("dip_no_press", {4'h0, button_press}, 8'h00);
        tick(1);
        check("dip_no_press2", {4'h0, button_press}, 8'h00);

        // reset with button 0 counter at 2
        button_raw = 4'hE;
        tick(4);
        rst_n = 1'b0;
        #1;
        exp_cnt = 8'h00;
        check("midrst_db", {4'h0, button_db}, 8'h0F);
        check("midrst_dip", {4'h0, dipsw_db}, 8'h00);
        check("midrst_count", press_count, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check("post_rst_db_hold", {button_press, button_db}, 8'h0F);
        tick(1);
        check("post_rst_db", {4'h0, button_db}, 8'h0E);
        check("post_rst_press", {4'h0, button_press}, 8'h01);
        check("post_rst_dip", {4'h0, dipsw_db}, 8'h0A);
        tick(1);
        check("post_rst_press_end", {4'h0, button_press}, 8'h00);
        bump(4'h1);
        check("post_rst_count", press_count, exp_cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/input_debounce.md
INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning the number of consecutive stable cycles needed to accept a new level (1 ms at 50 MHz); legal range is 2 or more.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the debounce counter width; it SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 clk_clk  in  1  single system clock; all logic is on its rising edge.
REQ-004 reset_reset_n  in  1  reset, asynchronous and active-low.
REQ-005 button_raw  in  4  raw KEY pins, active-low, asynchronous to clk_clk.
REQ-006 dipsw_raw  in  4  raw slide-switch pins, asynchronous to clk_clk.
REQ-007 button_db  out  4  debounced buttons, active-low; feeds the button PIO export.
REQ-008 dipsw_db  out  4  debounced switches; feeds the dipsw PIO export.
REQ-009 button_press  out  4  one-cycle pulse per accepted press (1->0 transition of button_db).
REQ-010 press_count  out  8  running count of accepted presses (see Configuration).

Function
REQ-011 The block SHALL treat all 8 inputs as independent channels: channels 0-3 are button_raw[3:0] and channels 4-7 are dipsw_raw[3:0].
REQ-012 Each channel SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Each channel SHALL have a CNT_W-bit counter and a stable register, which drives button_db or dipsw_db.
REQ-014 When the synchronized input equals the stable value, the counter SHALL be 0 on the next edge.
REQ-015 When the synchronized input differs and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-016 When the synchronized input differs and counter = DEBOUNCE_CYCLES-1, the stable register SHALL take the synchronized value and the counter SHALL be 0, both on the same edge.
REQ-017 Latency SHALL be fixed: a clean raw level change SHALL appear on the _db output exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it.
REQ-018 A raw pulse or glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave the output unchanged and clear the counter.
REQ-019 The counter SHALL never exceed DEBOUNCE_CYCLES-1, so it SHALL not wrap.
REQ-020 button_press[i] SHALL be registered and high for exactly the one cycle in which button_db[i] first reads 0 after reading 1.
REQ-021 A release (0->1) SHALL produce no pulse.
REQ-022 Simultaneous acceptances on several channels SHALL each be handled independently, in the same cycle.
REQ-023 The block SHALL have no handshakes; outputs are level or pulse only.

Reset
REQ-024 Asserting reset_reset_n low SHALL asynchronously force:
- button synchronizers and button_db to 4'hF (released);
- dipsw synchronizers and dipsw_db to 4'h0;
- all counters to 0;
- button_press to 4'h0;
- press_count to 8'h00.
REQ-025 Deassertion SHALL be synchronous to clk_clk at the integration level; the block adds no internal reset synchronizer.
REQ-026 Reset asserted mid-debounce SHALL discard the count.
REQ-027 After reset release, a level held on the raw input SHALL be accepted with the normal DEBOUNCE_CYCLES+2 latency; no pulse is produced for dipsw.

Configuration
REQ-028 The block SHALL use the macro INPUT_DEBOUNCE_PRESS_CNT_EN to compile the press counter in or out.
REQ-029 With the macro defined:
- press_count SHALL be an 8-bit register;
- each cycle it SHALL increase by the popcount of button_press, from 0 to 4;
- it SHALL wrap modulo 256 (8'hFF + 1 = 8'h00; 8'hFE + 2 presses = 8'h00).
REQ-030 With the macro undefined, press_count SHALL be tied to 8'h00 and no counter logic SHALL be synthesized.

Verification (DEBOUNCE_CYCLES=4, CNT_W=3)
REQ-031 Reset state: after reset, button_db=F, dipsw_db=0, button_press=0, press_count=00.
REQ-032 Clean press: button_raw[0] drops 1->0 and is held -> button_db[0]=0 exactly 6 edges later; button_press[0] high for 1 cycle on that same cycle; press_count=01 (macro on).
REQ-033 Bounce rejection: button_raw[2] sequence low 3 cycles / high 1 / low 2 / high -> button_db stays F and no pulse.
REQ-034 Simultaneous events: all 4 buttons pressed on the same edge with press_count=FE -> button_press=F for 1 cycle and press_count=02; with the macro undefined, press_count stays 00.
REQ-035 Switch path: dipsw_raw 0->A held -> dipsw_db=A after 6 edges; button_press stays 0.
REQ-036 Reset mid-debounce: reset asserted at counter=2 during a press, then released with raw still low -> button_db stays 1 for 6 edges after release, then goes 0 with one pulse.
